// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end between a CPU request port and a
// word-wide, byte-addressed memory. Accesses that straddle a word boundary
// are split into two word cycles (ACC1 then ACC2). Load bytes are gathered
// into a small buffer and then extended for the response.
module mem_access_unit #(
  parameter logic [31:0] pMemBytes = 32'd176
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic        iwReqValid,
  output logic        owReqReady,
  input  logic        iwReqWrite,
  input  logic [1:0]  iwReqSize,
  input  logic        iwReqSigned,
  input  logic [31:0] iwReqAddr,
  input  logic [31:0] iwReqData,
  output logic        owRspValid,
  input  logic        iwRspReady,
  output logic [31:0] owRspData,
  output logic        owRspError,
  output logic [31:0] owMemReadAddr,
  output logic [31:0] owMemWriteAddr,
  output logic [31:0] owMemWriteData,
  output logic [3:0]  owMemWstrb,
  input  logic [31:0] iwMemReadData
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t      state;
  state_t      state_next;

  logic        req_write;
  logic        req_signed;
  logic        req_cross;
  logic        req_error;
  logic [1:0]  req_size;
  logic [2:0]  req_bytes;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [7:0]  buffer [4];

  logic        accept;
  logic [2:0]  in_bytes;
  logic [32:0] in_last;
  logic        in_cross;
  logic        in_error;

  logic [3:0]  lane_hit;
  logic [2:0]  lane_k [4];
  logic [31:0] word_addr;
  logic [31:0] assembled;
  logic [31:0] load_result;

  assign accept    = iwReqValid && (state == IDLE);
  assign word_addr = {req_addr[31:2], 2'b00};

  // Decode the incoming request: byte count, boundary crossing and range error.
  always_comb begin
    in_bytes = 3'd4;
    case (iwReqSize)
      2'b00:   in_bytes = 3'd1;
      2'b01:   in_bytes = 3'd2;
      default: in_bytes = 3'd4;
    endcase
    in_last  = {1'b0, iwReqAddr} + {30'd0, in_bytes} - 33'd1;
    in_cross = ({1'b0, iwReqAddr[1:0]} + in_bytes) > 3'd4;
    in_error = (iwReqSize == 2'b11) || (in_last >= {1'b0, pMemBytes});
  end

  // Map each memory lane to a request byte index for the current access word.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      lane_hit[l] = 1'b0;
      lane_k[l]   = 3'd0;
      if (state == ACC1) begin
        lane_k[l]   = 3'(l) - {1'b0, req_addr[1:0]};
        lane_hit[l] = (3'(l) >= {1'b0, req_addr[1:0]}) && (lane_k[l] < req_bytes);
      end else if (state == ACC2) begin
        lane_k[l]   = 3'(l + 4) - {1'b0, req_addr[1:0]};
        lane_hit[l] = req_cross && (lane_k[l] < req_bytes);
      end
    end
  end

  // Assemble buffered load bytes and extend them to the response width.
  always_comb begin
    assembled   = {buffer[3], buffer[2], buffer[1], buffer[0]};
    load_result = assembled;
    case (req_size)
      2'b00:   load_result = req_signed ? {{24{assembled[7]}}, assembled[7:0]}
                                        : {24'd0, assembled[7:0]};
      2'b01:   load_result = req_signed ? {{16{assembled[15]}}, assembled[15:0]}
                                        : {16'd0, assembled[15:0]};
      default: load_result = assembled;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic: errors skip straight to the response.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = in_error ? RESP : ACC1;
      ACC1:    state_next = req_cross ? ACC2 : RESP;
      ACC2:    state_next = RESP;
      RESP:    if (iwRspReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the request on accept and collect load bytes at the end of each access cycle.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      req_write  <= 1'b0;
      req_signed <= 1'b0;
      req_cross  <= 1'b0;
      req_error  <= 1'b0;
      req_size   <= 2'd0;
      req_bytes  <= 3'd0;
      req_addr   <= 32'd0;
      req_data   <= 32'd0;
      for (int b = 0; b < 4; b++) buffer[b] <= 8'd0;
    end else if (accept) begin
      req_write  <= iwReqWrite;
      req_signed <= iwReqSigned;
      req_cross  <= in_cross;
      req_error  <= in_error;
      req_size   <= iwReqSize;
      req_bytes  <= in_bytes;
      req_addr   <= iwReqAddr;
      req_data   <= iwReqData;
      for (int b = 0; b < 4; b++) buffer[b] <= 8'd0;
    end else if (((state == ACC1) || (state == ACC2)) && !req_write) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_hit[l]) buffer[lane_k[l][1:0]] <= iwMemReadData[8*l +: 8];
      end
    end
  end

  // Output decode: handshake, response data, and memory address/strobe per access cycle.
  always_comb begin
    owReqReady     = (state == IDLE);
    owRspValid     = (state == RESP);
    owRspError     = (state == RESP) && req_error;
    owRspData      = 32'd0;
    owMemReadAddr  = 32'd0;
    owMemWriteAddr = 32'd0;
    owMemWriteData = 32'd0;
    owMemWstrb     = 4'b0000;
    if ((state == RESP) && !req_write && !req_error) owRspData = load_result;
    if ((state == ACC1) || (state == ACC2)) begin
      owMemReadAddr  = (state == ACC2) ? word_addr + 32'd4 : word_addr;
      owMemWriteAddr = owMemReadAddr;
      if (req_write) begin
        for (int l = 0; l < 4; l++) begin
          if (lane_hit[l]) begin
            owMemWstrb[l]          = 1'b1;
            owMemWriteData[8*l +: 8] = req_data[{lane_k[l][1:0], 3'b000} +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed test of mem_access_unit against a byte-array
// memory model that writes on negedge and reads combinationally.
module tb_mem_access_unit;

  localparam logic [31:0] MEM_BYTES = 32'd176;

  logic        iwClk = 1'b0;
  logic        iwnRst = 1'b0;
  logic        iwReqValid = 1'b0;
  logic        owReqReady;
  logic        iwReqWrite = 1'b0;
  logic [1:0]  iwReqSize = 2'b00;
  logic        iwReqSigned = 1'b0;
  logic [31:0] iwReqAddr = 32'd0;
  logic [31:0] iwReqData = 32'd0;
  logic        owRspValid;
  logic        iwRspReady = 1'b0;
  logic [31:0] owRspData;
  logic        owRspError;
  logic [31:0] owMemReadAddr;
  logic [31:0] owMemWriteAddr;
  logic [31:0] owMemWriteData;
  logic [3:0]  owMemWstrb;
  logic [31:0] iwMemReadData;

  logic [7:0]  mem [0:175];

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  mem_access_unit #(.pMemBytes(MEM_BYTES)) dut (
    .iwClk          (iwClk),
    .iwnRst         (iwnRst),
    .iwReqValid     (iwReqValid),
    .owReqReady     (owReqReady),
    .iwReqWrite     (iwReqWrite),
    .iwReqSize      (iwReqSize),
    .iwReqSigned    (iwReqSigned),
    .iwReqAddr      (iwReqAddr),
    .iwReqData      (iwReqData),
    .owRspValid     (owRspValid),
    .iwRspReady     (iwRspReady),
    .owRspData      (owRspData),
    .owRspError     (owRspError),
    .owMemReadAddr  (owMemReadAddr),
    .owMemWriteAddr (owMemWriteAddr),
    .owMemWriteData (owMemWriteData),
    .owMemWstrb     (owMemWstrb),
    .iwMemReadData  (iwMemReadData)
  );

  always #5 iwClk = ~iwClk;

  // Combinational memory read; lanes beyond the end of memory read as zero.
  always_comb begin
    iwMemReadData = 32'd0;
    for (int l = 0; l < 4; l++) begin
      if (owMemReadAddr + 32'(l) < MEM_BYTES)
        iwMemReadData[8*l +: 8] = mem[8'(owMemReadAddr + 32'(l))];
    end
  end

  // Memory contents start as 0x5A and take strobed bytes on every negedge.
  initial begin
    for (int i = 0; i < 176; i++) mem[i] = 8'h5A;
    forever begin
      @(negedge iwClk);
      for (int l = 0; l < 4; l++) begin
        if (owMemWstrb[l] && (owMemWriteAddr + 32'(l) < MEM_BYTES))
          mem[8'(owMemWriteAddr + 32'(l))] = owMemWriteData[8*l +: 8];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge iwClk);
    #1;
    edges++;
  endtask

  // Present one request and return just after the accepting edge.
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] d);
    checkOutput("req_ready_before", 32'(owReqReady), 32'd1);
    iwReqValid  = 1'b1;
    iwReqWrite  = w;
    iwReqSize   = sz;
    iwReqSigned = sg;
    iwReqAddr   = a;
    iwReqData   = d;
    @(posedge iwClk);
    #1;
    iwReqValid = 1'b0;
    edges      = 0;
  endtask

  // Wait (bounded) for the response, check it, optionally stall, then release it.
  task automatic finishResp(input string tag, input logic [31:0] exp_data,
                            input logic exp_err, input int exp_lat, input int hold);
    while (!owRspValid && edges < 10) step();
    checkOutput({tag, "_valid"},   32'(owRspValid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(edges + 1), 32'(exp_lat));
    checkOutput({tag, "_data"},    owRspData, exp_data);
    checkOutput({tag, "_error"},   32'(owRspError), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      step();
      checkOutput({tag, "_hold_valid"}, 32'(owRspValid), 32'd1);
      checkOutput({tag, "_hold_data"},  owRspData, exp_data);
      checkOutput({tag, "_hold_ready"}, 32'(owReqReady), 32'd0);
    end
    iwRspReady = 1'b1;
    step();
    iwRspReady = 1'b0;
    checkOutput({tag, "_idle_ready"}, 32'(owReqReady), 32'd1);
    checkOutput({tag, "_idle_valid"}, 32'(owRspValid), 32'd0);
  endtask

  initial begin
    #12;
    checkOutput("rst_req_ready", 32'(owReqReady), 32'd1);
    checkOutput("rst_rsp_valid", 32'(owRspValid), 32'd0);
    checkOutput("rst_rsp_error", 32'(owRspError), 32'd0);
    checkOutput("rst_rsp_data",  owRspData, 32'd0);
    checkOutput("rst_wstrb",     32'(owMemWstrb), 32'd0);
    checkOutput("rst_raddr",     owMemReadAddr, 32'd0);
    checkOutput("rst_wdata",     owMemWriteData, 32'd0);
    @(negedge iwClk);
    iwnRst = 1'b1;

    // Aligned word store accepted on the first edge after reset, then load back.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    checkOutput("sw8_acc1_raddr", owMemReadAddr, 32'h8);
    checkOutput("sw8_acc1_waddr", owMemWriteAddr, 32'h8);
    checkOutput("sw8_acc1_wstrb", 32'(owMemWstrb), 32'hF);
    checkOutput("sw8_acc1_wdata", owMemWriteData, 32'hDEADBEEF);
    checkOutput("sw8_acc1_ready", 32'(owReqReady), 32'd0);
    finishResp("sw8", 32'd0, 1'b0, 2, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'd0);
    checkOutput("lw8_acc1_wstrb", 32'(owMemWstrb), 32'd0);
    checkOutput("lw8_acc1_raddr", owMemReadAddr, 32'h8);
    finishResp("lw8", 32'hDEADBEEF, 1'b0, 2, 0);

    // Byte store, then signed/unsigned byte loads and a signed half load.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h5, 32'h00000080);
    checkOutput("sb5_acc1_addr",  owMemWriteAddr, 32'h4);
    checkOutput("sb5_acc1_wstrb", 32'(owMemWstrb), 32'b0010);
    checkOutput("sb5_acc1_wdata", owMemWriteData, 32'h00008000);
    finishResp("sb5", 32'd0, 1'b0, 2, 0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h5, 32'd0);
    finishResp("lb5_signed", 32'hFFFFFF80, 1'b0, 2, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h5, 32'd0);
    finishResp("lb5_unsigned", 32'h00000080, 1'b0, 2, 0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h4, 32'd0);
    finishResp("lh4_signed", 32'hFFFF805A, 1'b0, 2, 0);

    // Misaligned word store across 0x4/0x8, then load it back.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h6, 32'h11223344);
    checkOutput("sw6_acc1_addr",  owMemWriteAddr, 32'h4);
    checkOutput("sw6_acc1_wstrb", 32'(owMemWstrb), 32'b1100);
    checkOutput("sw6_acc1_wdata", owMemWriteData, 32'h33440000);
    step();
    checkOutput("sw6_acc2_addr",  owMemWriteAddr, 32'h8);
    checkOutput("sw6_acc2_wstrb", 32'(owMemWstrb), 32'b0011);
    checkOutput("sw6_acc2_wdata", owMemWriteData, 32'h00001122);
    finishResp("sw6", 32'd0, 1'b0, 3, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
    finishResp("lw6", 32'h11223344, 1'b0, 3, 0);

    // Range boundary: last legal half, one past the end, and the reserved size.
    applyStimulus(1'b0, 2'b01, 1'b0, 32'hAE, 32'd0);
    finishResp("lh_ae", 32'h00005A5A, 1'b0, 2, 0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'hAF, 32'd0);
    checkOutput("lh_af_wstrb", 32'(owMemWstrb), 32'd0);
    finishResp("lh_af", 32'd0, 1'b1, 1, 0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF);
    checkOutput("s11_wstrb", 32'(owMemWstrb), 32'd0);
    finishResp("s11", 32'd0, 1'b1, 1, 0);
    checkOutput("s11_mem0", 32'(mem[0]), 32'h5A);

    // Response stalled for five cycles must hold steady.
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h5, 32'd0);
    finishResp("hold", 32'h00000080, 1'b0, 2, 5);

    // Crossing store aborted by reset in ACC2: only the lower word is touched.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h13, 32'hCAFEBABE);
    checkOutput("abort_acc1_addr",  owMemWriteAddr, 32'h10);
    checkOutput("abort_acc1_wstrb", 32'(owMemWstrb), 32'b1000);
    checkOutput("abort_acc1_wdata", owMemWriteData, 32'hBE000000);
    step();
    checkOutput("abort_acc2_addr",  owMemWriteAddr, 32'h14);
    checkOutput("abort_acc2_wstrb", 32'(owMemWstrb), 32'b0111);
    checkOutput("abort_acc2_wdata", owMemWriteData, 32'h00CAFEBA);
    iwnRst = 1'b0;
    #1;
    checkOutput("abort_wstrb", 32'(owMemWstrb), 32'd0);
    checkOutput("abort_ready", 32'(owReqReady), 32'd1);
    checkOutput("abort_valid", 32'(owRspValid), 32'd0);
    @(negedge iwClk);
    #1;
    checkOutput("abort_mem13", 32'(mem[8'h13]), 32'hBE);
    checkOutput("abort_mem14", 32'(mem[8'h14]), 32'h5A);
    @(negedge iwClk);
    iwnRst = 1'b1;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    finishResp("abort_lw10", 32'hBE5A5A5A, 1'b0, 2, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
    finishResp("abort_lw14", 32'h5A5A5A5A, 1'b0, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
